// File: rtl/dm_port_arbiter_if.sv
// Bus bundle between the data-memory port arbiter, its two requesters and the memory.
// The slave modport is the arbiter's view; master is the view of whatever surrounds it.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [3:0]        ext_be;
  logic [31:0]       ext_wdata;
  logic              ext_gnt;
  logic [31:0]       ext_rdata;
  logic              ext_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              be_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_be, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata,
    output be_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_be, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata,
    input  be_err
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin sequencer sharing the single-port data memory between the CPU MEM stage
// and one external master; sequences the one-cycle read latency and gates illegal writes.
module dm_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  dm_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state;
  state_t            next_state;
  logic              owner;
  logic              last;
  logic              be_err_q;

  logic              issue;
  logic              winner;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              be_ok;
  logic              cpu_done;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b1111, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // A tie goes to whoever did not win last; winner 0 is the CPU, 1 is the external master.
  always_comb begin
    issue = (state == IDLE) && (bus.cpu_req || bus.ext_req);
    if (bus.cpu_req && bus.ext_req)
      winner = ~last;
    else
      winner = bus.ext_req;
    w_we    = winner ? bus.ext_we    : bus.cpu_we;
    w_addr  = winner ? bus.ext_addr  : bus.cpu_addr;
    w_be    = winner ? bus.ext_be    : bus.cpu_be;
    w_wdata = winner ? bus.ext_wdata : bus.cpu_wdata;
    be_ok   = be_legal(w_be);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (issue && !w_we) next_state = RD_WAIT;
      RD_WAIT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en     = issue;
    bus.mem_we     = issue && w_we && be_ok;
    bus.mem_addr   = {w_addr[ADDR_W-1:2], 2'b00};
    bus.mem_be     = w_we ? w_be : 4'b1111;
    bus.mem_wdata  = w_wdata;
    bus.ext_gnt    = issue && winner;
    bus.ext_rvalid = (state == RD_WAIT) && owner;
    cpu_done       = (issue && !winner && w_we) || ((state == RD_WAIT) && !owner);
    bus.cpu_stall  = bus.cpu_req && !cpu_done;
    // Reset must silence every strobe at once, not only after the next edge.
    if (reset) begin
      bus.mem_en     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.ext_gnt    = 1'b0;
      bus.ext_rvalid = 1'b0;
      bus.cpu_stall  = bus.cpu_req;
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ext_rdata = bus.mem_rdata;
  assign bus.be_err    = be_err_q;

  // last starts at EXT so the CPU wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= 1'b0;
      last     <= 1'b1;
      be_err_q <= 1'b0;
    end else if (issue) begin
      last <= winner;
      if (!w_we)
        owner <= winner;
      if (w_we && !be_ok)
        be_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small behavioural word memory behind the port.
module tb_dm_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dm_port_arbiter_if #(.ADDR_W(32)) bus ();

  dm_port_arbiter #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency byte-enabled memory standing in for the real data RAM.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr[7:2]];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic creq, input logic cwe, input logic [31:0] caddr,
                               input logic [3:0] cbe, input logic [31:0] cwd,
                               input logic ereq, input logic ewe, input logic [31:0] eaddr,
                               input logic [3:0] ebe, input logic [31:0] ewd);
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_be    = cbe;
    bus.cpu_wdata = cwd;
    bus.ext_req   = ereq;
    bus.ext_we    = ewe;
    bus.ext_addr  = eaddr;
    bus.ext_be    = ebe;
    bus.ext_wdata = ewd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idleInputs();

    // Reset state.
    sample();
    checkOutput("rst_mem_en", bus.mem_en, 1'b0);
    checkOutput("rst_ext_gnt", bus.ext_gnt, 1'b0);
    checkOutput("rst_be_err", bus.be_err, 1'b0);
    checkOutput("rst_stall_idle", bus.cpu_stall, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("rst_stall_req", bus.cpu_stall, 1'b1);
    checkOutput("rst_mem_en_req", bus.mem_en, 1'b0);
    tick();
    reset = 1'b0;

    // CPU sw 0x10.
    applyStimulus(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    sample();
    checkOutput("sw_mem_en", bus.mem_en, 1'b1);
    checkOutput("sw_mem_we", bus.mem_we, 1'b1);
    checkOutput("sw_mem_addr", bus.mem_addr, 32'h10);
    checkOutput("sw_stall", bus.cpu_stall, 1'b0);
    tick();

    // CPU lw 0x10.
    applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    sample();
    checkOutput("lw_issue_stall", bus.cpu_stall, 1'b1);
    checkOutput("lw_issue_we", bus.mem_we, 1'b0);
    checkOutput("lw_issue_be", bus.mem_be, 4'hF);
    tick();
    sample();
    checkOutput("lw_data_stall", bus.cpu_stall, 1'b0);
    checkOutput("lw_data_mem_en", bus.mem_en, 1'b0);
    checkOutput("lw_data", bus.cpu_rdata, 32'hDEADBEEF);
    tick();

    // CPU sb 0x13 then lw 0x10.
    applyStimulus(1'b1, 1'b1, 32'h13, 4'b1000, 32'h44000000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    sample();
    checkOutput("sb_mem_be", bus.mem_be, 4'b1000);
    checkOutput("sb_mem_addr", bus.mem_addr, 32'h10);
    checkOutput("sb_mem_we", bus.mem_we, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    sample();
    checkOutput("sb_readback", bus.cpu_rdata, 32'h44ADBEEF);
    tick();

    // EXT writes preload 0x20 and 0x40.
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h11112222);
    sample();
    checkOutput("ew1_gnt", bus.ext_gnt, 1'b1);
    checkOutput("ew1_mem_we", bus.mem_we, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h33334444);
    sample();
    checkOutput("ew2_gnt", bus.ext_gnt, 1'b1);
    tick();
    idleInputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Tie after reset: CPU lw 0x20 vs EXT lw 0x40, both held.
    applyStimulus(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    sample();
    checkOutput("tie_c0_addr", bus.mem_addr, 32'h20);
    checkOutput("tie_c0_gnt", bus.ext_gnt, 1'b0);
    checkOutput("tie_c0_stall", bus.cpu_stall, 1'b1);
    tick();
    sample();
    checkOutput("tie_c1_stall", bus.cpu_stall, 1'b0);
    checkOutput("tie_c1_rdata", bus.cpu_rdata, 32'h11112222);
    checkOutput("tie_c1_rvalid", bus.ext_rvalid, 1'b0);
    tick();
    sample();
    checkOutput("tie_c2_addr", bus.mem_addr, 32'h40);
    checkOutput("tie_c2_gnt", bus.ext_gnt, 1'b1);
    checkOutput("tie_c2_stall", bus.cpu_stall, 1'b1);
    tick();
    sample();
    checkOutput("tie_c3_rvalid", bus.ext_rvalid, 1'b1);
    checkOutput("tie_c3_rdata", bus.ext_rdata, 32'h33334444);
    checkOutput("tie_c3_stall", bus.cpu_stall, 1'b1);
    tick();
    sample();
    checkOutput("tie_c4_addr", bus.mem_addr, 32'h20);
    checkOutput("tie_c4_gnt", bus.ext_gnt, 1'b0);
    tick();
    sample();
    checkOutput("tie_c5_stall", bus.cpu_stall, 1'b0);
    tick();
    sample();
    checkOutput("tie_c6_gnt", bus.ext_gnt, 1'b1);
    tick();
    idleInputs();
    sample();
    checkOutput("tie_c7_rvalid", bus.ext_rvalid, 1'b1);
    tick();

    // EXT write with illegal be 0101.
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h20, 4'b0101, 32'hFFFFFFFF);
    sample();
    checkOutput("ill_gnt", bus.ext_gnt, 1'b1);
    checkOutput("ill_mem_we", bus.mem_we, 1'b0);
    checkOutput("ill_be_err_pre", bus.be_err, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    sample();
    checkOutput("ill_be_err_post", bus.be_err, 1'b1);
    tick();
    sample();
    checkOutput("ill_mem_unchanged", bus.cpu_rdata, 32'h11112222);
    tick();

    // Legal half-word write 1100 still writes.
    applyStimulus(1'b1, 1'b1, 32'h42, 4'b1100, 32'hAAAA0000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    sample();
    checkOutput("hw_mem_we", bus.mem_we, 1'b1);
    checkOutput("hw_be_err_sticky", bus.be_err, 1'b1);
    tick();

    // EXT read, reset in RD_WAIT.
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    sample();
    checkOutput("rr_gnt", bus.ext_gnt, 1'b1);
    tick();
    idleInputs();
    reset = 1'b1;
    sample();
    checkOutput("rr_rvalid", bus.ext_rvalid, 1'b0);
    checkOutput("rr_mem_en", bus.mem_en, 1'b0);
    checkOutput("rr_mem_we", bus.mem_we, 1'b0);
    checkOutput("rr_ext_gnt", bus.ext_gnt, 1'b0);
    checkOutput("rr_stall", bus.cpu_stall, 1'b0);
    checkOutput("rr_be_err", bus.be_err, 1'b0);
    tick();
    sample();
    checkOutput("rr_rvalid_hold", bus.ext_rvalid, 1'b0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    sample();
    checkOutput("rr_tie_addr", bus.mem_addr, 32'h20);
    checkOutput("rr_tie_gnt", bus.ext_gnt, 1'b0);
    checkOutput("rr_tie_stall", bus.cpu_stall, 1'b1);
    tick();
    idleInputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Sequencer and arbiter for the single-port data memory. It shares the memory's word port, with 4-bit byte enables, between the CPU MEM stage and one external master (DMA or debug). It issues exactly one access at a time, sequences the memory's one-cycle read latency, and stalls the CPU while the port is busy. Byte enables arrive already decoded from the store type and address bits [1:0]. This block validates them and gates writes that carry an illegal pattern.

## Interface
- ADDR_W, 32, byte-address width for both requesters and the memory.

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request, level, held until cpu_stall=0
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  byte address
- cpu_be  in  4  byte enables (store); ignored for loads
- cpu_wdata  in  32  store data, already lane-aligned
- cpu_rdata  out  32  load data, valid when cpu_req & ~cpu_we & ~cpu_stall
- cpu_stall  out  1  freeze MEM stage and upstream
- ext_req, ext_we, ext_addr, ext_be, ext_wdata  in  1/1/ADDR_W/4/32  external master request, same meaning as cpu_*
- ext_gnt  out  1  one-cycle pulse: request accepted; master may change inputs next cycle
- ext_rdata  out  32  read data
- ext_rvalid  out  1  one-cycle pulse, ext_rdata valid
- mem_en, mem_we  out  1/1  memory access strobe / write strobe
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}
- mem_be  out  4  write byte enables; 4'b1111 on reads
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, valid the cycle after a read issue
- be_err  out  1  sticky: a write with an illegal byte-enable pattern was seen

## Operation
- State machine has two states: IDLE and RD_WAIT. A 1-bit `owner` register holds the requester being served (0=CPU, 1=EXT). A 1-bit `last` register holds the last granted requester.
- IDLE, no request: mem_en=0. No change to state or `last`.
- IDLE, one requester active: that requester wins.
- IDLE, both requesters active: the requester not equal to `last` wins (round-robin).
  - On a win, `last` <= winner.
  - mem_en=1, and mem_addr, mem_be and mem_wdata are muxed combinationally from the winner.
- Winner is a write:
  - mem_we=1 only when be is legal, and the write commits at this edge. State stays IDLE.
  - Legal be patterns are 1111, 0001, 0010, 0100, 1000, 0011 and 1100. Any other pattern, including 0000, forces mem_we=0 and sets be_err.
  - An illegal write still completes normally.
  - CPU winner: cpu_stall=0 this cycle.
  - EXT winner: ext_gnt=1 this cycle.
- Winner is a read: mem_we=0, owner <= winner, next state RD_WAIT. An EXT winner gets ext_gnt=1 this cycle. A CPU winner sees cpu_stall=1.
- RD_WAIT: mem_en=0 and no new issue. Data is routed by `owner`:
  - owner=CPU: cpu_rdata=mem_rdata, cpu_stall=0.
  - owner=EXT: ext_rdata=mem_rdata, ext_rvalid=1.
  - Next state is IDLE in both cases.
- cpu_stall = cpu_req & ~(CPU completes this cycle). A CPU request that loses arbitration, or arrives during RD_WAIT for EXT, stays stalled.
- cpu_rdata and ext_rdata are passed through from mem_rdata combinationally. They are only meaningful in their valid cycle.

## Timing
- Reset (asynchronous) sets state=IDLE, owner=0, last=1 (so the CPU wins the first tie), and be_err=0.
- While reset is high: mem_en=mem_we=ext_gnt=ext_rvalid=0 and cpu_stall=cpu_req.
- Latency:
  - Write: 1 cycle, zero CPU stall cycles.
  - Read: 2 cycles (issue, then data), one CPU stall cycle.
  - Losing a tie adds the winner's full latency.
- Back-to-back issue:
  - A write in IDLE can be followed by any issue in the next cycle.
  - After a read, the earliest next issue is the cycle after RD_WAIT.
- Bandwidth split: under continuous dual requests, grants alternate between CPU and EXT with no starvation. Worst-case CPU wait is one EXT read (2 cycles).
- Reset mid-read (in RD_WAIT): the read is abandoned and no ext_rvalid is produced. The CPU re-presents the request after reset.
- EXT must hold its inputs until ext_gnt. A change before grant is treated as a new request.
- be_err is cleared only by reset.

## Test plan
- CPU sw: cpu_addr=0x0000_0010, be=1111, wdata=0xDEADBEEF, no EXT.
  - Required: mem_en=mem_we=1, mem_addr=0x10 and cpu_stall=0, all in the same cycle.
  - A following lw at 0x10 gives cpu_stall=1 for one cycle, then cpu_rdata=0xDEADBEEF with stall=0.
- CPU sb at 0x13 with be=1000 and wdata=0x44000000, then lw at 0x10.
  - Required: mem_be=1000 and mem_addr=0x10; the readback's top byte is 0x44.
- Tie after reset: CPU lw 0x20 and EXT lw 0x40 asserted together and held.
  - Required: CPU is issued first (cycle 0), its data arrives in cycle 1, EXT is issued in cycle 2 with ext_gnt, and ext_rvalid comes in cycle 3.
  - With both held continuously, winners alternate CPU, EXT, CPU, and so on.
- EXT write with illegal be=0101.
  - Required: ext_gnt=1, mem_we=0, memory unchanged, and be_err=1 from the next cycle until reset.
- EXT read issued, then reset asserted in RD_WAIT.
  - Required: no ext_rvalid pulse, all outputs 0, be_err=0.
  - After reset release, a CPU/EXT tie is won by the CPU.
